// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, constants and helpers for mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic {ARB, LOCK} arb_state_t;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: flop-based FIFO of requester ids for reads awaiting return data.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic            i_clk_ahb,
  input  logic            i_rstn_ahb,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_id_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0]   wr_q, rd_q;
  logic [ID_W-1:0] mem_q [DEPTH];
  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o   = wr_q == rd_q;
  assign head_id_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= push_id_i;
        wr_q                <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among NUM_REQ requesters with round-robin grant and read-return routing.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          i_clk_ahb,
  input  logic                          i_rstn_ahb,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_req_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_req_rd_data,
  output logic                          o_valid,
  output logic                          o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  input  logic                          i_ready,
  input  logic                          i_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_rd_data,
  output logic                          o_rd_orphan
);
  localparam int IDW = clog2_min1(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  arb_state_t     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, grant, arb_id, start, head_id;
  logic [NUM_REQ-1:0] elig;
  logic full, empty, xfer, push, pop;
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
    logic [IDW:0] s;
    s = {1'b0, a} + (IDW+1)'(b);
    return (s >= (IDW+1)'(NUM_REQ)) ? IDW'(s - (IDW+1)'(NUM_REQ)) : IDW'(s);
  endfunction
  // Writes bypass the tag FIFO, so only reads are held off when it is full.
  assign elig = i_req_valid & (i_req_rd0_wr1 | {NUM_REQ{!full}});
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] rr_q, rr_d;
  assign start = rr_q;
  assign rr_d  = xfer ? wrap_add(grant, 1) : rr_q;
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) rr_q <= '0;
    else rr_q <= rr_d;
  end
`endif
  // Scan downward so the lowest offset from start is the one that sticks.
  always_comb begin
    arb_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (elig[wrap_add(start, i)]) arb_id = wrap_add(start, i);
  end
  assign grant   = (state_q == LOCK) ? grant_q : arb_id;
  assign o_valid = i_rstn_ahb && ((state_q == LOCK) || (|elig));
  assign xfer    = o_valid && i_ready;
  always_comb begin
    o_addr    = '0;
    o_wr_data = '0;
    o_rd0_wr1 = RD;
    for (int k = 0; k < NUM_REQ; k++)
      if (o_valid && grant == IDW'(k)) begin
        o_addr    = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        o_wr_data = i_req_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_rd0_wr1 = i_req_rd0_wr1[k];
      end
  end
  assign o_req_ready    = xfer ? (ONE << grant) : '0;
  assign push           = xfer && (o_rd0_wr1 == RD);
  assign pop            = i_rstn_ahb && i_rd_valid && !empty;
  assign o_rd_orphan    = i_rstn_ahb && i_rd_valid && empty;
  assign o_req_rd_valid = pop ? (ONE << head_id) : '0;
  assign o_req_rd_data  = pop ? i_rd_data : '0;
  always_comb begin
    state_d = (state_q == ARB) ? ((o_valid && !i_ready) ? LOCK : ARB) : (i_ready ? ARB : LOCK);
    grant_d = (state_q == ARB && o_valid && !i_ready) ? arb_id : grant_q;
  end
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q <= ARB;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end
  mem_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .ID_W(IDW)) u_tag_fifo (
    .i_clk_ahb (i_clk_ahb),
    .i_rstn_ahb(i_rstn_ahb),
    .push_i    (push),
    .push_id_i (grant),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (full),
    .empty_o   (empty)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (2 requesters, 4 outstanding reads).
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [1:0]  rv, rw;
  logic [31:0] a0, a1, d0, d1;
  logic        rdy, mrv;
  logic [31:0] mrd;
  logic [1:0]  ordy, orv;
  logic [31:0] ord, oaddr, owd;
  logic        ov, orw, orph;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .i_clk_ahb     (clk),
    .i_rstn_ahb    (rstn),
    .i_req_valid   (rv),
    .i_req_rd0_wr1 (rw),
    .i_req_addr    ({a1, a0}),
    .i_req_wr_data ({d1, d0}),
    .o_req_ready   (ordy),
    .o_req_rd_valid(orv),
    .o_req_rd_data (ord),
    .o_valid       (ov),
    .o_rd0_wr1     (orw),
    .o_addr        (oaddr),
    .o_wr_data     (owd),
    .i_ready       (rdy),
    .i_rd_valid    (mrv),
    .i_rd_data     (mrd),
    .o_rd_orphan   (orph)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rv = 2'b01; rw = 2'b01; a0 = 32'h10; d0 = 32'hA5A5A5A5; a1 = '0; d1 = '0;
    rdy = 1'b1; mrv = 1'b0; mrd = '0;
    #12;
    chk("rst_valid", 32'(ov), 0);
    chk("rst_ready", 32'(ordy), 0);
    chk("rst_addr", oaddr, 0);
    chk("rst_orphan", 32'(orph), 0);
    rstn = 1'b1;
    #1;
    chk("wr0_valid", 32'(ov), 1);
    chk("wr0_addr", oaddr, 32'h10);
    chk("wr0_data", owd, 32'hA5A5A5A5);
    chk("wr0_rw", 32'(orw), 1);
    chk("wr0_ready", 32'(ordy), 1);
    cyc(); rv = 2'b10; rw = 2'b10; a1 = 32'h20; d1 = 32'h5A; #1;
    chk("wr1_ready", 32'(ordy), 2);
    chk("wr1_addr", oaddr, 32'h20);
    cyc(); rv = 2'b00; #1;
    chk("idle_valid", 32'(ov), 0);
    chk("idle_addr", oaddr, 0);
    chk("idle_wdata", owd, 0);
    chk("idle_rw", 32'(orw), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); rv = 2'b11; rw = 2'b00; a0 = 32'h100; a1 = 32'h200; #1;
      chk("rr_ready", 32'(ordy), (i % 2) ? 2 : 1);
      chk("rr_addr", oaddr, (i % 2) ? 32'h200 : 32'h100);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); rv = 2'b00; mrv = 1'b1; mrd = 32'(i + 1); #1;
      chk("rd_route", 32'(orv), (i % 2) ? 2 : 1);
      chk("rd_data", ord, 32'(i + 1));
    end
    cyc(); mrv = 1'b0; mrd = 32'hFFFF; #1;
    chk("rd_data_idle", ord, 0);
    chk("rd_valid_idle", 32'(orv), 0);
    cyc(); rv = 2'b10; rw = 2'b11; a1 = 32'h30; d1 = 32'h33; rdy = 1'b0; mrd = '0; #1;
    chk("lk_valid", 32'(ov), 1);
    chk("lk_addr", oaddr, 32'h30);
    chk("lk_ready", 32'(ordy), 0);
    for (int j = 0; j < 2; j++) begin
      cyc(); rv = 2'b11; a0 = 32'h40; d0 = 32'h44; #1;
      chk("lk_hold_valid", 32'(ov), 1);
      chk("lk_hold_addr", oaddr, 32'h30);
      chk("lk_hold_ready", 32'(ordy), 0);
    end
    cyc(); rdy = 1'b1; #1;
    chk("lk_done_ready", 32'(ordy), 2);
    chk("lk_done_addr", oaddr, 32'h30);
    cyc(); rv = 2'b01; #1;
    chk("after_lk_ready", 32'(ordy), 1);
    chk("after_lk_addr", oaddr, 32'h40);
    for (int i = 0; i < 4; i++) begin
      cyc(); rv = 2'b01; rw = 2'b00; a0 = 32'h300; #1;
      chk("fill_ready", 32'(ordy), 1);
    end
    cyc(); rv = 2'b11; rw = 2'b10; a1 = 32'h50; d1 = 32'h55; #1;
    chk("full_wr_ready", 32'(ordy), 2);
    chk("full_wr_rw", 32'(orw), 1);
    chk("full_wr_addr", oaddr, 32'h50);
    cyc(); rv = 2'b01; mrv = 1'b1; mrd = 32'hDEAD; #1;
    chk("full_pop_valid", 32'(ov), 0);
    chk("full_pop_ready", 32'(ordy), 0);
    chk("full_pop_route", 32'(orv), 1);
    chk("full_pop_data", ord, 32'hDEAD);
    cyc(); mrv = 1'b0; #1;
    chk("full_regrant_ready", 32'(ordy), 1);
    chk("full_regrant_addr", oaddr, 32'h300);
    cyc(); rv = 2'b10; rw = 2'b10; a1 = 32'h70; rdy = 1'b0; #1;
    chk("lk2_valid", 32'(ov), 1);
    chk("lk2_addr", oaddr, 32'h70);
    cyc(); rstn = 1'b0; #1;
    chk("rst_mid_valid", 32'(ov), 0);
    chk("rst_mid_ready", 32'(ordy), 0);
    chk("rst_mid_addr", oaddr, 0);
    cyc(); rstn = 1'b1; rv = 2'b01; rw = 2'b01; a0 = 32'h60; rdy = 1'b1; mrv = 1'b1; mrd = 32'hBEEF; #1;
    chk("post_rst_addr", oaddr, 32'h60);
    chk("post_rst_ready", 32'(ordy), 1);
    chk("orphan_pulse", 32'(orph), 1);
    chk("orphan_route", 32'(orv), 0);
    chk("orphan_data", ord, 0);
    cyc(); mrv = 1'b0; rv = 2'b01; rw = 2'b00; a0 = 32'h64; #1;
    chk("orphan_clear", 32'(orph), 0);
    chk("post_rst_rd_ready", 32'(ordy), 1);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      cyc(); rv = 2'b11; rw = 2'b11; a0 = 32'h80; a1 = 32'h90; #1;
      chk("fixed_prio_ready", 32'(ordy), 1);
    end
`endif
    cyc(); rv = 2'b00;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
